sum_of_squares: RTL and testbench

Computes the squared Euclidean norm of a signed Q12.4 vector (x²+y²+z², plus w² when quaternion mode is compiled in) and streams the Q12.4 result to the fastInvSqrt core over a valid/ready handshake. It is the stage directly upstream of fastInvSqrt in the Madgwick filter datapath, used for accelerometer, magnetometer and quaternion normalisation. A single multiplier is time-shared across the vector elements, one element per cycle.

---
 rtl/sum_of_squares_pkg.sv | 31 +++
 rtl/sum_of_squares_if.sv | 45 ++++
 rtl/sum_of_squares_square_accumulate.sv | 38 +++
 rtl/sum_of_squares.sv | 135 +++++++++++++
 tb/tb_sum_of_squares.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sum_of_squares_pkg.sv
`default_nettype none
// =============================================================================
// Module      : sos_pkg
// Description : Shared types and constants for the sum_of_squares block.
//               SOS_QUAT_EN selects the 4-element (quaternion) build.
// Revision    : 1.0  initial release
// =============================================================================
package sos_pkg;
    localparam int INT_WIDTH   = 12;
    localparam int FRACT_WIDTH = 4;
    localparam int W           = INT_WIDTH + FRACT_WIDTH;

`ifdef SOS_QUAT_EN
    localparam int N_ELEM = 4;
`else
    localparam int N_ELEM = 3;
`endif

    // Two guard bits: four squares of at most 2^30 each fit without wrap.
    localparam int ACC_W = 2 * W + 2;
    localparam int IDX_W = 2;

    localparam logic [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        OUT   = 2'd2
    } state_t;
endpackage
`default_nettype wire

// File: rtl/sum_of_squares_if.sv
`default_nettype none
// =============================================================================
// Module      : sum_of_squares_if
// Description : Vector-in / result-out handshake bundle of sum_of_squares.
//               w_in exists only when SOS_QUAT_EN is defined.
// Revision    : 1.0  initial release
// =============================================================================
interface sum_of_squares_if;
    import sos_pkg::*;

    logic signed [W-1:0] x_in;
    logic signed [W-1:0] y_in;
    logic signed [W-1:0] z_in;
`ifdef SOS_QUAT_EN
    logic signed [W-1:0] w_in;
`endif
    logic                valid_in;
    logic                ready_in;
    logic        [W-1:0] data_out;
    logic                valid_out;
    logic                ready_out;
    logic                zero_out;
    logic                sat_out;

`ifdef SOS_QUAT_EN
    modport master (
        output x_in, y_in, z_in, w_in, valid_in, ready_out,
        input  ready_in, data_out, valid_out, zero_out, sat_out
    );
    modport slave (
        input  x_in, y_in, z_in, w_in, valid_in, ready_out,
        output ready_in, data_out, valid_out, zero_out, sat_out
    );
`else
    modport master (
        output x_in, y_in, z_in, valid_in, ready_out,
        input  ready_in, data_out, valid_out, zero_out, sat_out
    );
    modport slave (
        input  x_in, y_in, z_in, valid_in, ready_out,
        output ready_in, data_out, valid_out, zero_out, sat_out
    );
`endif
endinterface
`default_nettype wire

// File: rtl/sum_of_squares_square_accumulate.sv
`default_nettype none
// =============================================================================
// Module      : square_accumulate
// Description : Single-multiplier square-and-add accumulator with clear/enable.
//               Exposes the next accumulator value so the caller can latch the
//               final sum on the same edge as the last accumulation.
// Revision    : 1.0  initial release
// =============================================================================
module square_accumulate
    import sos_pkg::*;
(
    input  wire logic                clk,
    input  wire logic                rst_n,
    input  wire logic                i_clear,
    input  wire logic                i_en,
    input  wire logic signed [W-1:0] i_operand,
    output logic         [ACC_W-1:0] o_acc_next
);
    logic         [ACC_W-1:0] r_acc;
    logic signed  [2*W-1:0]   w_op_ext;
    logic signed  [2*W-1:0]   w_square;

    // The exact square never exceeds 2^30, so a 2W signed product is non-negative.
    assign w_op_ext   = (2*W)'(i_operand);
    assign w_square   = w_op_ext * w_op_ext;
    assign o_acc_next = r_acc + {2'b00, w_square};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (i_clear) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= o_acc_next;
        end
    end
endmodule
`default_nettype wire

// File: rtl/sum_of_squares.sv
`default_nettype none
// =============================================================================
// Module      : sum_of_squares
// Description : Q12.4 squared norm (x^2+y^2+z^2[+w^2]) with valid/ready I/O.
//               Define SOS_QUAT_EN for the 4-element quaternion variant.
// Revision    : 1.0  initial release
// =============================================================================
module sum_of_squares
    import sos_pkg::*;
(
    input  wire logic       clk,
    input  wire logic       rst_n,
    sum_of_squares_if.slave bus
);
    localparam logic [IDX_W-1:0] c_IDX_LAST = IDX_W'(N_ELEM - 1);

    state_t              r_state;
    state_t              w_state_next;
    logic    [IDX_W-1:0] r_idx;
    logic signed [W-1:0] r_elem [N_ELEM];
    logic                r_ready;
    logic                r_valid;
    logic        [W-1:0] r_data;
    logic                r_zero;
    logic                r_sat;

    logic                w_accept;
    logic                w_last;
    logic signed [W-1:0] w_operand;
    logic    [ACC_W-1:0] w_acc_next;
    logic    [ACC_W-1:0] w_shift;
    logic                w_sat;
    logic        [W-1:0] w_result;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_ready && bus.valid_in) begin
                    w_accept     = 1'b1;
                    w_state_next = ACCUM;
                end
            end
            ACCUM: begin
                if (r_idx == c_IDX_LAST) begin
                    w_last       = 1'b1;
                    w_state_next = OUT;
                end
            end
            OUT: begin
                if (bus.ready_out) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N_ELEM; i++) begin
                r_elem[i] <= '0;
            end
            r_idx <= '0;
        end else if (w_accept) begin
            r_elem[0] <= bus.x_in;
            r_elem[1] <= bus.y_in;
            r_elem[2] <= bus.z_in;
`ifdef SOS_QUAT_EN
            r_elem[3] <= bus.w_in;
`endif
            r_idx     <= '0;
        end else if (r_state == ACCUM) begin
            r_idx <= r_idx + 1'b1;
        end
    end

    always_comb begin
        w_operand = '0;
        for (int i = 0; i < N_ELEM; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_operand = r_elem[i];
            end
        end
    end

    square_accumulate u_square_accumulate (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clear    (w_accept),
        .i_en       (r_state == ACCUM),
        .i_operand  (w_operand),
        .o_acc_next (w_acc_next)
    );

    // Truncate the fractional bits of the Q24.8 sum back to Q12.4.
    assign w_shift  = w_acc_next >> FRACT_WIDTH;
    assign w_sat    = (w_shift > ACC_W'(SAT_MAX));
    assign w_result = w_sat ? SAT_MAX : w_shift[W-1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ready <= 1'b0;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_zero  <= 1'b0;
            r_sat   <= 1'b0;
        end else begin
            r_ready <= (w_state_next == IDLE);
            r_valid <= (w_state_next == OUT);
            if (w_last) begin
                r_data <= w_result;
                r_zero <= (w_result == '0);
                r_sat  <= w_sat;
            end
        end
    end

    assign bus.ready_in  = r_ready;
    assign bus.valid_out = r_valid;
    assign bus.data_out  = r_data;
    assign bus.zero_out  = r_zero;
    assign bus.sat_out   = r_sat;
endmodule
`default_nettype wire

// File: tb/tb_sum_of_squares.sv
`default_nettype none
// =============================================================================
// Module      : tb_sum_of_squares
// Description : Scoreboard bench for sum_of_squares (SOS_QUAT_EN aware).
// Revision    : 1.0  initial release
// =============================================================================
module tb_sum_of_squares;
    import sos_pkg::*;

    typedef struct {
        logic [15:0] data;
        logic        zero;
        logic        sat;
    } exp_t;

    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    sum_of_squares_if bus ();

    sum_of_squares dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [15:0] x, y, z, w);
        exp_t   e;
        longint v[4];
        longint s;
        v[0] = longint'($signed(x));
        v[1] = longint'($signed(y));
        v[2] = longint'($signed(z));
        v[3] = longint'($signed(w));
        s = 0;
        for (int i = 0; i < N_ELEM; i++) s += v[i] * v[i];
        s = s >> 4;
        if (s > 32767) begin
            e.data = 16'h7FFF;
            e.sat  = 1'b1;
        end else begin
            e.data = s[15:0];
            e.sat  = 1'b0;
        end
        e.zero = (e.data == 16'h0000);
        return e;
    endfunction

    // Waits (bounded) for ready_in, presents the vector for one accepting edge.
    task automatic send_vector(input logic [15:0] x, y, z, w, output bit ok);
        int cnt = 0;
        while (bus.ready_in !== 1'b1 && cnt < 64) begin
            @(posedge clk); #1;
            cnt++;
        end
        ok = (bus.ready_in === 1'b1);
        bus.x_in = x;
        bus.y_in = y;
        bus.z_in = z;
`ifdef SOS_QUAT_EN
        bus.w_in = w;
`endif
        bus.valid_in = 1'b1;
        sb.push_back(model(x, y, z, w));
        @(posedge clk); #1;
        bus.valid_in = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (bus.valid_out !== 1'b1 && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic handshake();
        bus.ready_out = 1'b1;
        @(posedge clk); #1;
        bus.ready_out = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.valid_in = 1'b0; bus.ready_out = 1'b0;
        bus.x_in = '0; bus.y_in = '0; bus.z_in = '0;
`ifdef SOS_QUAT_EN
        bus.w_in = '0;
`endif
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.ready_in !== 1'b0 || bus.valid_out !== 1'b0 || bus.data_out !== 16'h0000 ||
            bus.zero_out !== 1'b0 || bus.sat_out !== 1'b0)
        begin
            errors++;
            $display("FAIL reset_outputs: got rdy=%b vld=%b data=%h zero=%b sat=%b want all 0",
                     bus.ready_in, bus.valid_out, bus.data_out, bus.zero_out, bus.sat_out);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.ready_in !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b want 1", bus.ready_in);
        end
    endtask

    // ready_out is raised before valid_out to cover the early-ready case.
    task automatic test_unit();
        bit   ok;
        int   lat;
        exp_t e;
        bus.ready_out = 1'b1;
        send_vector(16'h0010, 16'h0010, 16'h0010, 16'h0010, ok);
        wait_valid(lat);
        checks++;
        if (!ok || lat != N_ELEM) begin
            errors++;
            $display("FAIL unit_latency: got ok=%0d lat=%0d want ok=1 lat=%0d", ok, lat, N_ELEM);
        end
        e = sb.pop_front();
        checks++;
        if (bus.data_out !== e.data || bus.zero_out !== e.zero || bus.sat_out !== e.sat) begin
            errors++;
            $display("FAIL unit_result: got %h/%b/%b want %h/%b/%b", bus.data_out, bus.zero_out,
                     bus.sat_out, e.data, e.zero, e.sat);
        end
`ifndef SOS_QUAT_EN
        checks++;
        if (bus.data_out !== 16'h0030) begin
            errors++;
            $display("FAIL unit_literal: got %h want 0030", bus.data_out);
        end
`endif
        @(posedge clk); #1;
        bus.ready_out = 1'b0;
        checks++;
        if (bus.valid_out !== 1'b0 || bus.ready_in !== 1'b1) begin
            errors++;
            $display("FAIL unit_release: got vld=%b rdy=%b want 0/1", bus.valid_out, bus.ready_in);
        end
    endtask

    // Sign, saturation and truncation corner vectors.
    task automatic test_patterns();
        logic [15:0] tv[4][4] = '{
            '{16'hFFE0, 16'h0000, 16'h0000, 16'h0000},
            '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF},
            '{16'h0001, 16'h0000, 16'h0000, 16'h0000},
            '{16'h8000, 16'h0000, 16'h0000, 16'h0000}
        };
        bit   ok;
        int   lat;
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            send_vector(tv[i][0], tv[i][1], tv[i][2], tv[i][3], ok);
            wait_valid(lat);
            checks++;
            if (!ok || lat != N_ELEM) begin
                errors++;
                $display("FAIL pattern%0d_latency: got ok=%0d lat=%0d want 1/%0d", i, ok, lat, N_ELEM);
            end
            e = sb.pop_front();
            checks++;
            if (bus.data_out !== e.data || bus.zero_out !== e.zero || bus.sat_out !== e.sat) begin
                errors++;
                $display("FAIL pattern%0d_result: got %h/%b/%b want %h/%b/%b", i, bus.data_out,
                         bus.zero_out, bus.sat_out, e.data, e.zero, e.sat);
            end
            handshake();
        end
    endtask

    // ready_out held high: each vector issued as soon as ready_in returns.
    task automatic test_back_to_back();
        bit          ok;
        int          lat;
        exp_t        e;
        logic [15:0] v[4];
        bus.ready_out = 1'b1;
        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < 4; k++) v[k] = 16'($urandom_range(0, 16'hFFFF) >> (i % 3) * 4);
            send_vector(v[0], v[1], v[2], v[3], ok);
            wait_valid(lat);
            e = sb.pop_front();
            checks++;
            if (!ok || lat != N_ELEM || bus.data_out !== e.data || bus.zero_out !== e.zero ||
                bus.sat_out !== e.sat)
            begin
                errors++;
                $display("FAIL b2b%0d: got ok=%0d lat=%0d %h/%b/%b want lat=%0d %h/%b/%b", i, ok,
                         lat, bus.data_out, bus.zero_out, bus.sat_out, N_ELEM, e.data, e.zero, e.sat);
            end
            @(posedge clk); #1;
        end
        bus.ready_out = 1'b0;
    endtask

    task automatic test_backpressure();
        bit          ok;
        int          lat;
        exp_t        e;
        logic [15:0] held;
        bus.ready_out = 1'b0;
        send_vector(16'h0030, 16'hFFF0, 16'h0008, 16'h0004, ok);
        wait_valid(lat);
        e = sb.pop_front();
        held = bus.data_out;
        checks++;
        if (!ok || lat != N_ELEM || bus.data_out !== e.data || bus.sat_out !== e.sat) begin
            errors++;
            $display("FAIL bp_first: got lat=%0d data=%h want lat=%0d data=%h", lat,
                     bus.data_out, N_ELEM, e.data);
        end
        bus.x_in = 16'h0040; bus.y_in = 16'h0000; bus.z_in = 16'h0010;
`ifdef SOS_QUAT_EN
        bus.w_in = 16'h0000;
`endif
        bus.valid_in = 1'b1;
        sb.push_back(model(16'h0040, 16'h0000, 16'h0010, 16'h0000));
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (bus.valid_out !== 1'b1 || bus.data_out !== held || bus.ready_in !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d: got vld=%b data=%h rdy=%b want 1/%h/0", i,
                         bus.valid_out, bus.data_out, bus.ready_in, held);
            end
        end
        bus.ready_out = 1'b1;
        @(posedge clk); #1;
        bus.ready_out = 1'b0;
        checks++;
        if (bus.valid_out !== 1'b0 || bus.ready_in !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: got vld=%b rdy=%b want 0/1", bus.valid_out, bus.ready_in);
        end
        @(posedge clk); #1;
        bus.valid_in = 1'b0;
        wait_valid(lat);
        e = sb.pop_front();
        checks++;
        if (lat != N_ELEM || bus.data_out !== e.data || bus.zero_out !== e.zero) begin
            errors++;
            $display("FAIL bp_second: got lat=%0d data=%h want lat=%0d data=%h", lat,
                     bus.data_out, N_ELEM, e.data);
        end
        handshake();
    endtask

    task automatic test_reset_mid();
        bit   ok;
        int   lat;
        bit   seen;
        exp_t e;
        bus.ready_out = 1'b1;
        send_vector(16'h0100, 16'h0100, 16'h0100, 16'h0100, ok);
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checks++;
        if (bus.ready_in !== 1'b0 || bus.valid_out !== 1'b0) begin
            errors++;
            $display("FAIL midrst_during: got rdy=%b vld=%b want 0/0", bus.ready_in, bus.valid_out);
        end
        seen = 1'b0;
        for (int i = 0; i < N_ELEM + 2; i++) begin
            @(posedge clk); #1;
            if (bus.valid_out !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen || bus.ready_in !== 1'b1) begin
            errors++;
            $display("FAIL midrst_after: got stray_valid=%0d rdy=%b want 0/1", seen, bus.ready_in);
        end
        send_vector(16'h0020, 16'h0000, 16'h0000, 16'h0000, ok);
        wait_valid(lat);
        e = sb.pop_front();
        checks++;
        if (!ok || lat != N_ELEM || bus.data_out !== 16'h0040 || bus.data_out !== e.data) begin
            errors++;
            $display("FAIL midrst_next: got lat=%0d data=%h want lat=%0d data=0040", lat,
                     bus.data_out, N_ELEM);
        end
        @(posedge clk); #1;
        bus.ready_out = 1'b0;
    endtask

    initial begin
        test_reset();
        test_unit();
        test_patterns();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
